imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Sequences program loading into instruction_memory through its debug port. Takes a byte stream
//  (UART RX or a bench) framed as a 32-bit word count followed by payload, and assembles
//  little-endian words. Writes each word at consecutive addresses and holds the core
//  (cpu_hold) until the load completes. Sits between the host link and imem; it is the
//  only master of the debug_* port.
// PARAMETERS
//  BASE_ADDR       32'h0000_0000  byte address of first written word (word aligned)
//  MAX_WORDS       1024           largest accepted word count (imem depth)
//  TIMEOUT_CYCLES  100000         max idle cycles between accepted bytes while loading
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  reset           in   1   asynchronous, active-high reset
//  start           in   1   begin a load session (single-cycle pulse)
//  rx_data         in   8   incoming byte
//  rx_valid        in   1   rx_data valid
//  rx_ready        out  1   loader accepts byte; transfer = rx_valid & rx_ready
//  debug_en        out  1   to imem debug_en
//  debug_write_en  out  1   to imem debug_write_en
//  debug_addr      out  32  to imem debug_addr
//  debug_data_in   out  32  to imem debug_data_in (write data)
//  debug_data_out  in   32  from imem combinational read (used only with verify)
//  cpu_hold        out  1   keep core in reset/stall while high
//  busy            out  1   session in progress
//  done            out  1   level: last session completed OK
//  error           out  1   level: last session aborted
//  words_loaded    out  11  words written in current/last session
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0, rx_ready 0, counters and partial word cleared.
//    Reset mid-load aborts; words already written stay in imem.
//  - States: IDLE, HDR, DATA, WRITE, VERIFY (macro only), DONE, ERROR.
//  - IDLE/DONE/ERROR + start -> HDR; clears done, error, words_loaded, byte/timeout counters.
//    start in HDR/DATA/WRITE/VERIFY is ignored.
//  - HDR: rx_ready=1; 4 bytes form count N, first byte = N[7:0]. After 4th byte: N==0 or
//    N>MAX_WORDS -> ERROR, else -> DATA.
//  - DATA: rx_ready=1; byte k of word lands in bits [8k+7:8k]. 4th byte accepted in cycle t
//    -> WRITE in cycle t+1.
//  - WRITE (exactly 1 cycle): rx_ready=0; debug_en=debug_write_en=1;
//    debug_addr=BASE_ADDR+4*words_loaded (32-bit wrap); words_loaded increments at cycle end.
//    Next: VERIFY if enabled, else DATA if words_loaded<N, else DONE.
//  - DONE: done=1, cpu_hold=0, busy=0. ERROR: error=1, cpu_hold=1 (core stays held).
//  - cpu_hold=1 and busy=1 in HDR, DATA, WRITE, VERIFY; cpu_hold=0 in IDLE and DONE.
//  - debug_en=0 outside WRITE/VERIFY; debug_addr/debug_data_in hold last value.
//  - Timeout: in HDR/DATA, the counter clears on each accepted byte and increments otherwise.
//    Reaching TIMEOUT_CYCLES -> ERROR; partial word discarded.
//  - A byte presented while rx_ready=0 is not consumed; the source must hold it.
// CONFIGURATION
//  IMEM_LOAD_VERIFY_EN defined: after WRITE, 1-cycle VERIFY with debug_en=1,
//    debug_write_en=0, same debug_addr. If debug_data_out != written word -> ERROR,
//    else continue as after WRITE (DATA/DONE). Each word costs 2 non-accepting cycles.
//  Undefined: no VERIFY state; debug_data_out ignored; each word costs 1 non-accepting cycle.
// TESTING
//  1. start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013@0x0,
//     0x00100093@0x4; done=1, words_loaded=2, cpu_hold 1->0.
//  2. Header 00 00 00 00 -> error=1 after 4th byte, no debug_write_en pulse; header N=1025
//     -> error=1.
//  3. N=1, send 2 payload bytes then idle TIMEOUT_CYCLES -> error=1, cpu_hold=1,
//     words_loaded=0.
//  4. rx_valid held high continuously -> rx_ready low exactly 1 cycle (2 with verify) after
//     every 4th payload byte; no byte lost or duplicated.
//  5. Assert reset mid-DATA -> all outputs 0 immediately (async); start again loads correctly.
//  6. VERIFY_EN: force debug_data_out mismatch in VERIFY -> error=1, words_loaded=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a byte stream (32-bit LE word count, then LE payload words) into imem
// debug-port writes while holding the core. Optional read-back check: IMEM_LOAD_VERIFY_EN.
module imem_boot_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        debug_en_o,
   output logic        debug_write_en_o,
   output logic [31:0] debug_addr_o,
   output logic [31:0] debug_data_in_o,
   input  logic [31:0] debug_data_out_i,
   output logic        cpu_hold_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [10:0] words_loaded_o
);

   typedef enum logic [2:0] {
      StIdle, StHdr, StData, StWrite, StDone, StError
`ifdef IMEM_LOAD_VERIFY_EN
      , StVerify
`endif
   } state_e;

   state_e      state_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] shift_q;
   logic [31:0] count_q;
   logic [31:0] tmo_q;
   logic [10:0] words_q;
   logic        rx_ready_q;
   logic        debug_en_q;
   logic        debug_we_q;
   logic [31:0] debug_addr_q;
   logic [31:0] debug_data_q;
   logic        cpu_hold_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;

   logic        xfer;
   logic [31:0] full_word;
   logic        timed_out;
   logic [10:0] words_next;
   logic        more_after_write;
   logic [31:0] wr_addr;

   assign xfer             = rx_valid_i & rx_ready_q;
   assign full_word        = {rx_data_i, shift_q};
   assign timed_out        = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
   assign words_next       = words_q + 11'd1;
   assign more_after_write = {21'b0, words_next} < count_q;
   assign wr_addr          = BASE_ADDR + {19'b0, words_q, 2'b00};

`ifdef IMEM_LOAD_VERIFY_EN
   logic more_after_verify;
   // words_q has already been bumped by the time VERIFY runs
   assign more_after_verify = {21'b0, words_q} < count_q;
`else
   logic unused_data;
   assign unused_data = ^debug_data_out_i;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         byte_idx_q   <= 2'd0;
         shift_q      <= '0;
         count_q      <= '0;
         tmo_q        <= '0;
         words_q      <= '0;
         rx_ready_q   <= 1'b0;
         debug_en_q   <= 1'b0;
         debug_we_q   <= 1'b0;
         debug_addr_q <= '0;
         debug_data_q <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone, StError: begin
               if (start_i) begin
                  state_q    <= StHdr;
                  byte_idx_q <= 2'd0;
                  shift_q    <= '0;
                  tmo_q      <= '0;
                  words_q    <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  rx_ready_q <= 1'b1;
                  cpu_hold_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end

            StHdr: begin
               if (xfer) begin
                  tmo_q <= '0;
                  if (byte_idx_q == 2'd3) begin
                     byte_idx_q <= 2'd0;
                     shift_q    <= '0;
                     count_q    <= full_word;
                     if (full_word == 32'd0 || full_word > 32'(MAX_WORDS)) begin
                        state_q    <= StError;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        rx_ready_q <= 1'b0;
                     end else begin
                        state_q <= StData;
                     end
                  end else begin
                     unique case (byte_idx_q)
                        2'd0:    shift_q[7:0]   <= rx_data_i;
                        2'd1:    shift_q[15:8]  <= rx_data_i;
                        default: shift_q[23:16] <= rx_data_i;
                     endcase
                     byte_idx_q <= byte_idx_q + 2'd1;
                  end
               end else if (timed_out) begin
                  state_q    <= StError;
                  error_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  rx_ready_q <= 1'b0;
                  byte_idx_q <= 2'd0;
                  shift_q    <= '0;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end

            StData: begin
               if (xfer) begin
                  tmo_q <= '0;
                  if (byte_idx_q == 2'd3) begin
                     byte_idx_q   <= 2'd0;
                     shift_q      <= '0;
                     debug_data_q <= full_word;
                     debug_addr_q <= wr_addr;
                     debug_en_q   <= 1'b1;
                     debug_we_q   <= 1'b1;
                     rx_ready_q   <= 1'b0;
                     state_q      <= StWrite;
                  end else begin
                     unique case (byte_idx_q)
                        2'd0:    shift_q[7:0]   <= rx_data_i;
                        2'd1:    shift_q[15:8]  <= rx_data_i;
                        default: shift_q[23:16] <= rx_data_i;
                     endcase
                     byte_idx_q <= byte_idx_q + 2'd1;
                  end
               end else if (timed_out) begin
                  // partial word is dropped; nothing reaches imem
                  state_q    <= StError;
                  error_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  rx_ready_q <= 1'b0;
                  byte_idx_q <= 2'd0;
                  shift_q    <= '0;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end

            StWrite: begin
               words_q    <= words_next;
               tmo_q      <= '0;
               debug_we_q <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
               state_q    <= StVerify;
`else
               debug_en_q <= 1'b0;
               if (more_after_write) begin
                  state_q    <= StData;
                  rx_ready_q <= 1'b1;
               end else begin
                  state_q    <= StDone;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
`endif
            end

`ifdef IMEM_LOAD_VERIFY_EN
            StVerify: begin
               debug_en_q <= 1'b0;
               if (debug_data_out_i != debug_data_q) begin
                  state_q <= StError;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (more_after_verify) begin
                  state_q    <= StData;
                  rx_ready_q <= 1'b1;
               end else begin
                  state_q    <= StDone;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end
`endif

            default: state_q <= StIdle;
         endcase
      end
   end

   assign rx_ready_o       = rx_ready_q;
   assign debug_en_o       = debug_en_q;
   assign debug_write_en_o = debug_we_q;
   assign debug_addr_o     = debug_addr_q;
   assign debug_data_in_o  = debug_data_q;
   assign cpu_hold_o       = cpu_hold_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign error_o          = error_q;
   assign words_loaded_o   = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected imem writes are queued as bytes are issued,
// a negedge monitor pops and compares every debug write.
module tb_imem_boot_loader;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int MAXW = 16;
   localparam int TMO  = 40;
`ifdef IMEM_LOAD_VERIFY_EN
   localparam int STALL = 2;
`else
   localparam int STALL = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready, debug_en, debug_write_en, cpu_hold, busy, done, error;
   logic [31:0] debug_addr, debug_data_in, debug_data_out;
   logic [10:0] words_loaded;

   imem_boot_loader #(
      .BASE_ADDR      (BASE),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .start_i          (start),
      .rx_data_i        (rx_data),
      .rx_valid_i       (rx_valid),
      .rx_ready_o       (rx_ready),
      .debug_en_o       (debug_en),
      .debug_write_en_o (debug_write_en),
      .debug_addr_o     (debug_addr),
      .debug_data_in_o  (debug_data_in),
      .debug_data_out_i (debug_data_out),
      .cpu_hold_o       (cpu_hold),
      .busy_o           (busy),
      .done_o           (done),
      .error_o          (error),
      .words_loaded_o   (words_loaded)
   );

   always #5 clk = ~clk;

   // imem stand-in with combinational read; corrupt flips read data for the mismatch case
   logic [31:0] mem [MAXW];
   logic [31:0] corrupt = 32'h0;
   logic [31:0] off;
   assign off            = debug_addr - BASE;
   assign debug_data_out = mem[off[5:2]] ^ corrupt;
   always @(negedge clk) if (!reset && debug_en && debug_write_en) mem[off[5:2]] <= debug_data_in;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t         exp_q[$];
   logic [31:0] load_w[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && debug_en && debug_write_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h with no write expected",
                     debug_addr, debug_data_in);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", debug_addr, e.a);
            check("write_data", debug_data_in, e.d);
         end
      end
   end

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (rx_ready) ok = 1'b1;
         else stall_cnt++;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL rx_ready_wait: got rx_ready=0 for 200 cycles expected 1");
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send_byte(w[8*k +: 8]);
      end
   endtask

   // Loads load_w; expected writes come straight from word index and value.
   task automatic good_load(input bit cont, input bit poke_start);
      int n;
      n = load_w.size();
      pulse_start();
      check("hold_after_start", {31'b0, cpu_hold}, 1);
      check("busy_after_start", {31'b0, busy}, 1);
      check("done_cleared", {31'b0, done}, 0);
      send_word(n, !cont);
      stall_cnt = 0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{a: BASE + 32'(4 * i), d: load_w[i]});
         if (poke_start && i == 0) start = 1'b1;
         send_word(load_w[i], !cont);
         start = 1'b0;
      end
      if (cont) check("stall_cycles", stall_cnt, (n - 1) * STALL);
      idle(4);
      check("done", {31'b0, done}, 1);
      check("error_clear", {31'b0, error}, 0);
      check("words_loaded", {21'b0, words_loaded}, n);
      check("hold_released", {31'b0, cpu_hold}, 0);
      check("busy_clear", {31'b0, busy}, 0);
      check("missing_writes", exp_q.size(), 0);
      for (int i = 0; i < n; i++) check("imem_content", mem[i], load_w[i]);
   endtask

   task automatic bad_header(input logic [31:0] n);
      pulse_start();
      send_word(n, 1'b0);
      idle(3);
      check("hdr_error", {31'b0, error}, 1);
      check("hdr_done", {31'b0, done}, 0);
      check("hdr_hold", {31'b0, cpu_hold}, 1);
      check("hdr_busy", {31'b0, busy}, 0);
      check("hdr_rx_ready", {31'b0, rx_ready}, 0);
      check("hdr_words", {21'b0, words_loaded}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_ready", {31'b0, rx_ready}, 0);
      check("rst_hold", {31'b0, cpu_hold}, 0);
      check("rst_debug_en", {31'b0, debug_en}, 0);
      check("rst_status", {29'b0, busy, done, error}, 0);
      reset = 1'b0;
      idle(2);

      // directed program
      load_w = '{32'h0000_0013, 32'h0010_0093};
      good_load(1'b1, 1'b0);

      // header boundaries
      bad_header(32'd0);
      bad_header(32'(MAXW + 1));
      bad_header(32'hFFFF_FFFF);
      load_w.delete();
      for (int i = 0; i < MAXW; i++) load_w.push_back($urandom);
      good_load(1'b1, 1'b0);

      // randomized loads, with gaps, back-to-back and with stray start pulses
      for (int r = 0; r < 4; r++) begin
         load_w.delete();
         for (int i = 0; i < int'($urandom_range(1, MAXW)); i++) load_w.push_back($urandom);
         good_load(r[0], r == 2);
      end

      // timeout with a partial word
      pulse_start();
      send_word(32'd1, 1'b0);
      send_byte(8'hAA);
      send_byte(8'h55);
      idle(TMO - 5);
      check("tmo_early", {31'b0, error}, 0);
      check("tmo_busy", {31'b0, busy}, 1);
      idle(10);
      check("tmo_error", {31'b0, error}, 1);
      check("tmo_hold", {31'b0, cpu_hold}, 1);
      check("tmo_words", {21'b0, words_loaded}, 0);

      // timeout while waiting for the header
      pulse_start();
      idle(TMO + 5);
      check("tmo_hdr_error", {31'b0, error}, 1);

      // asynchronous reset mid-DATA
      pulse_start();
      send_word(32'd3, 1'b0);
      exp_q.push_back('{a: BASE, d: 32'hCAFE_F00D});
      send_word(32'hCAFE_F00D, 1'b0);
      send_byte(8'h11);
      #2;
      reset = 1'b1;
      #1;
      check("async_rx_ready", {31'b0, rx_ready}, 0);
      check("async_hold_busy", {30'b0, cpu_hold, busy}, 0);
      check("async_debug", {30'b0, debug_en, debug_write_en}, 0);
      check("async_addr", debug_addr, 0);
      check("async_data", debug_data_in, 0);
      check("async_words", {21'b0, words_loaded}, 0);
      check("async_status", {30'b0, done, error}, 0);
      check("async_pending", exp_q.size(), 0);
      exp_q.delete();
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
      load_w = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_BEEF};
      good_load(1'b0, 1'b0);

`ifdef IMEM_LOAD_VERIFY_EN
      // read-back mismatch stops after the first word
      corrupt = 32'h0000_0001;
      pulse_start();
      send_word(32'd2, 1'b0);
      exp_q.push_back('{a: BASE, d: 32'h0000_00FF});
      send_word(32'h0000_00FF, 1'b0);
      idle(4);
      check("verify_error", {31'b0, error}, 1);
      check("verify_words", {21'b0, words_loaded}, 1);
      check("verify_rx_ready", {31'b0, rx_ready}, 0);
      corrupt = 32'h0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
